// File: rtl/kanade_pkg.sv
// Shared definitions for the KANADE32 pipeline control slice: stage indices,
// register address width and the per-stage shadow record used for hazard tracking.
package kanade_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam int REG_AW = 5;

  // What the sequencer remembers about the instruction sitting in one stage.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } stage_info_t;

endpackage

// File: rtl/pipe_ctrl_hazard.sv
// Read-after-write detector: compares the decode-stage source registers against
// the destinations of older, still-uncommitted instructions in the shadow array.
module pipe_ctrl_hazard
  import kanade_pkg::*;
#(
  parameter int STAGES    = 5,
  parameter int BYPASS_WB = 0
) (
  input  stage_info_t [STAGES-1:0] shadow_i,
  input  logic [REG_AW-1:0]        d_rs_i,
  input  logic [REG_AW-1:0]        d_rt_i,
  input  logic                     d_use_rs_i,
  input  logic                     d_use_rt_i,
  output logic                     hz_o
);

  // A write-through regfile already delivers the write-back value to decode,
  // so the last stage only needs comparing when that bypass is absent.
  localparam int LastK = (BYPASS_WB != 0) ? STAGES - 2 : STAGES - 1;

  logic anyHit;
  logic unused_fields;

  // Not every shadow field matters to the compare; fold them into a sink.
  assign unused_fields = ^shadow_i;

  // Any valid, register-writing producer whose rd matches a live nonzero source.
  always_comb begin
    anyHit = 1'b0;
    for (int k = STG_EX; k <= LastK; k++) begin
      if (shadow_i[k].valid && shadow_i[k].reg_write) begin
        if (d_use_rs_i && (d_rs_i != '0) && (d_rs_i == shadow_i[k].rd)) anyHit = 1'b1;
        if (d_use_rt_i && (d_rt_i != '0) && (d_rt_i == shadow_i[k].rd)) anyHit = 1'b1;
      end
    end
    hz_o = shadow_i[STG_ID].valid & anyHit;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: produces PC / inter-stage load enables, per-stage valids and
// RAM ownership, inserting bubbles for RAW hazards and RAM conflicts, flushing on
// taken branches and counting stall cycles.
module pipe_ctrl
  import kanade_pkg::*;
#(
  parameter int STAGES    = 5,
  parameter int MEM_STAGE = 3,
  parameter int REG_AW    = kanade_pkg::REG_AW,
  parameter int BYPASS_WB = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic              d_use_rs,
  input  logic              d_use_rt,
  input  logic [REG_AW-1:0] d_rd,
  input  logic              d_reg_write,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic              branch_taken,
  output logic              pc_wren,
  output logic              pc_redirect,
  output logic              ram_addr_src,
  output logic [STAGES-2:0] stage_wren,
  output logic [STAGES-1:0] stage_valid,
  output logic              mem_wren,
  output logic              reg_wren,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Index 0 is never populated: fetch has no decoded information yet.
  stage_info_t [STAGES-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]         stallCnt_q, stallCnt_d;

  logic memBusy;
  logic branchFlush;
  logic rawHazard;

  assign memBusy     = shadow_q[MEM_STAGE].valid &
                       (shadow_q[MEM_STAGE].mem_read | shadow_q[MEM_STAGE].mem_write);
  assign branchFlush = shadow_q[MEM_STAGE].valid & branch_taken;

  pipe_ctrl_hazard #(
    .STAGES    (STAGES),
    .BYPASS_WB (BYPASS_WB)
  ) u_hazard (
    .shadow_i   (shadow_q),
    .d_rs_i     (d_rs),
    .d_rt_i     (d_rt),
    .d_use_rs_i (d_use_rs),
    .d_use_rt_i (d_use_rt),
    .hz_o       (rawHazard)
  );

  // Output decode with priority branch > hazard > memory conflict > normal; reset silences everything.
  always_comb begin
    pc_wren      = 1'b0;
    pc_redirect  = 1'b0;
    ram_addr_src = 1'b0;
    stage_wren   = '0;
    stage_valid  = '0;
    mem_wren     = 1'b0;
    reg_wren     = 1'b0;
    if (!reset) begin
      ram_addr_src   = memBusy;
      stage_valid[0] = run & ~memBusy;
      for (int i = 1; i < STAGES; i++) begin
        stage_valid[i] = shadow_q[i].valid;
      end
      if (run) begin
        mem_wren = shadow_q[MEM_STAGE].valid & shadow_q[MEM_STAGE].mem_write;
        reg_wren = shadow_q[STAGES-1].valid & shadow_q[STAGES-1].reg_write;
        if (branchFlush) begin
          pc_wren     = 1'b1;
          pc_redirect = 1'b1;
          stage_wren  = '1;
        end else if (rawHazard) begin
          stage_wren    = '1;
          stage_wren[0] = 1'b0;
        end else if (memBusy) begin
          stage_wren = '1;
        end else begin
          pc_wren    = 1'b1;
          stage_wren = '1;
        end
      end
    end
  end

  // Shadow advance: everything shifts one stage, then the winning case kills or holds slots.
  always_comb begin
    shadow_d = shadow_q;
    if (run) begin
      for (int i = STAGES - 1; i > STG_EX; i--) begin
        shadow_d[i] = shadow_q[i-1];
      end
      shadow_d[STG_EX].valid     = shadow_q[STG_ID].valid;
      shadow_d[STG_EX].rd        = d_rd;
      shadow_d[STG_EX].reg_write = d_reg_write;
      shadow_d[STG_EX].mem_read  = d_mem_read;
      shadow_d[STG_EX].mem_write = d_mem_write;
      if (branchFlush) begin
        for (int i = STG_ID; i <= MEM_STAGE; i++) begin
          shadow_d[i].valid = 1'b0;
        end
      end else if (rawHazard) begin
        shadow_d[STG_ID]       = shadow_q[STG_ID];
        shadow_d[STG_EX].valid = 1'b0;
      end else if (memBusy) begin
        shadow_d[STG_ID].valid = 1'b0;
      end else begin
        shadow_d[STG_ID].valid = 1'b1;
      end
    end
  end

  // Stall counter: one count per running cycle in which the PC did not load, saturating.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (run && !pc_wren && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + 1'b1;
    end
  end

  assign stall_cnt = reset ? '0 : stallCnt_q;

  // State registers; reset discards every in-flight instruction and clears the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q   <= '0;
      stallCnt_q <= '0;
    end else begin
      shadow_q   <= shadow_d;
      stallCnt_q <= stallCnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: a hand-computed vector table, directed multi-cycle
// sequences and random stimulus checked against an instruction-slot model.
module tb_pipe_ctrl;

  localparam int STAGES  = 5;
  localparam int MEM     = 3;
  localparam int LAST    = STAGES - 1;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset, run;
  logic [4:0] d_rs, d_rt, d_rd;
  logic d_use_rs, d_use_rt, d_reg_write, d_mem_read, d_mem_write, branch_taken;

  logic pc_wren, pc_redirect, ram_addr_src, mem_wren, reg_wren;
  logic [STAGES-2:0] stage_wren;
  logic [STAGES-1:0] stage_valid;
  logic [CNT_W-1:0] stall_cnt;

  logic byp_pc_wren, byp_pc_redirect, byp_ram_addr_src, byp_mem_wren, byp_reg_wren;
  logic [STAGES-2:0] byp_stage_wren;
  logic [STAGES-1:0] byp_stage_valid;
  logic [CNT_W-1:0] byp_stall_cnt;

  int checks = 0;
  int failures = 0;
  int cycleNo = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(STAGES), .MEM_STAGE(MEM), .REG_AW(5), .BYPASS_WB(0), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_rd(d_rd),
    .d_reg_write(d_reg_write), .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .branch_taken(branch_taken),
    .pc_wren(pc_wren), .pc_redirect(pc_redirect), .ram_addr_src(ram_addr_src),
    .stage_wren(stage_wren), .stage_valid(stage_valid),
    .mem_wren(mem_wren), .reg_wren(reg_wren), .stall_cnt(stall_cnt)
  );

  pipe_ctrl #(.STAGES(STAGES), .MEM_STAGE(MEM), .REG_AW(5), .BYPASS_WB(1), .CNT_W(CNT_W)) dutByp (
    .clk(clk), .reset(reset), .run(run),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .d_rd(d_rd),
    .d_reg_write(d_reg_write), .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .branch_taken(branch_taken),
    .pc_wren(byp_pc_wren), .pc_redirect(byp_pc_redirect), .ram_addr_src(byp_ram_addr_src),
    .stage_wren(byp_stage_wren), .stage_valid(byp_stage_valid),
    .mem_wren(byp_mem_wren), .reg_wren(byp_reg_wren), .stall_cnt(byp_stall_cnt)
  );

  typedef struct {
    bit reset; bit run;
    bit [4:0] rs; bit [4:0] rt; bit urs; bit urt;
    bit [4:0] rd; bit rw; bit mr; bit mw; bit bt;
  } in_t;

  typedef struct {
    in_t in;
    bit pc; bit redir; bit ram;
    bit [3:0] sw; bit [4:0] sv;
    bit mw; bit rw; bit [3:0] cnt;
  } vec_t;

  // Instruction slots of the reference pipeline (index 0 unused).
  typedef struct { bit valid; int rd; bit rw; bit mr; bit mw; } slot_t;
  typedef enum int {ACT_RESET, ACT_FROZEN, ACT_BRANCH, ACT_HAZARD, ACT_MEM, ACT_NORMAL} act_t;

  slot_t pipe [STAGES];
  int stallModel = 0;

  function automatic in_t inp(bit rst, bit rn, bit [4:0] rs, bit [4:0] rt, bit urs, bit urt,
                              bit [4:0] rd, bit rw, bit mr, bit mw, bit bt);
    in_t x;
    x.reset = rst; x.run = rn; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt;
    x.rd = rd; x.rw = rw; x.mr = mr; x.mw = mw; x.bt = bt;
    return x;
  endfunction

  function automatic vec_t mk(in_t x, bit pc, bit redir, bit ram, bit [3:0] sw, bit [4:0] sv,
                              bit mw, bit rw, bit [3:0] cnt);
    vec_t v;
    v.in = x; v.pc = pc; v.redir = redir; v.ram = ram; v.sw = sw; v.sv = sv;
    v.mw = mw; v.rw = rw; v.cnt = cnt;
    return v;
  endfunction

  function automatic bit readsReg(bit use_, logic [4:0] src, int rd);
    return use_ && (src != 0) && (int'(src) == rd);
  endfunction

  // Which rule governs the current cycle, from the model slots and the driven inputs.
  function automatic act_t decide();
    bit memOp, raw;
    if (reset) return ACT_RESET;
    if (!run) return ACT_FROZEN;
    memOp = pipe[MEM].valid && (pipe[MEM].mr || pipe[MEM].mw);
    raw = 1'b0;
    if (pipe[1].valid) begin
      for (int k = 2; k <= LAST; k++) begin
        if (pipe[k].valid && pipe[k].rw &&
            (readsReg(d_use_rs, d_rs, pipe[k].rd) || readsReg(d_use_rt, d_rt, pipe[k].rd)))
          raw = 1'b1;
      end
    end
    if (pipe[MEM].valid && branch_taken) return ACT_BRANCH;
    if (raw) return ACT_HAZARD;
    if (memOp) return ACT_MEM;
    return ACT_NORMAL;
  endfunction

  task automatic checkVal(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycleNo, actual, expected);
    end
  endtask

  task automatic applyStimulus(in_t x);
    reset = x.reset; run = x.run;
    d_rs = x.rs; d_rt = x.rt; d_use_rs = x.urs; d_use_rt = x.urt;
    d_rd = x.rd; d_reg_write = x.rw; d_mem_read = x.mr; d_mem_write = x.mw;
    branch_taken = x.bt;
    @(negedge clk);
  endtask

  // Compares every DUT output with what the model says this cycle must look like.
  task automatic checkOutput();
    act_t a;
    bit expPc, expRedir, expRam, expMw, expRw;
    logic [STAGES-2:0] expSw;
    logic [STAGES-1:0] expSv;
    int expCnt;
    a = decide();
    expPc = 0; expRedir = 0; expRam = 0; expMw = 0; expRw = 0;
    expSw = '0; expSv = '0; expCnt = 0;
    if (a != ACT_RESET) begin
      expRam = pipe[MEM].valid && (pipe[MEM].mr || pipe[MEM].mw);
      expSv[0] = run && !expRam;
      for (int i = 1; i < STAGES; i++) expSv[i] = pipe[i].valid;
      expCnt = stallModel;
      if (run) begin
        expMw = pipe[MEM].valid && pipe[MEM].mw;
        expRw = pipe[LAST].valid && pipe[LAST].rw;
        expSw = '1;
        case (a)
          ACT_BRANCH: begin expPc = 1; expRedir = 1; end
          ACT_HAZARD: expSw[0] = 1'b0;
          ACT_NORMAL: expPc = 1;
          default: ;
        endcase
      end
    end
    checkVal("pc_wren", 32'(pc_wren), 32'(expPc));
    checkVal("pc_redirect", 32'(pc_redirect), 32'(expRedir));
    checkVal("ram_addr_src", 32'(ram_addr_src), 32'(expRam));
    checkVal("stage_wren", 32'(stage_wren), 32'(expSw));
    checkVal("stage_valid", 32'(stage_valid), 32'(expSv));
    checkVal("mem_wren", 32'(mem_wren), 32'(expMw));
    checkVal("reg_wren", 32'(reg_wren), 32'(expRw));
    checkVal("stall_cnt", 32'(stall_cnt), 32'(expCnt));
  endtask

  // Moves the model instructions across the clock edge according to the winning rule.
  task automatic clockEdge();
    act_t a;
    slot_t decoded, bubble, fresh;
    a = decide();
    bubble = '{1'b0, 0, 1'b0, 1'b0, 1'b0};
    fresh = '{1'b1, 0, 1'b0, 1'b0, 1'b0};
    decoded = '{pipe[1].valid, int'(d_rd), d_reg_write, d_mem_read, d_mem_write};
    @(posedge clk);
    case (a)
      ACT_RESET: begin
        for (int i = 0; i < STAGES; i++) pipe[i] = bubble;
        stallModel = 0;
      end
      ACT_FROZEN: ;
      default: begin
        if ((a == ACT_HAZARD || a == ACT_MEM) && stallModel < CNT_MAX) stallModel++;
        for (int i = LAST; i >= 3; i--) pipe[i] = pipe[i-1];
        pipe[2] = decoded;
        if (a == ACT_BRANCH) begin
          for (int i = 1; i <= MEM; i++) pipe[i] = bubble;
        end else if (a == ACT_HAZARD) begin
          pipe[2] = bubble;
        end else if (a == ACT_MEM) begin
          pipe[1] = bubble;
        end else begin
          pipe[1] = fresh;
        end
      end
    endcase
    cycleNo++;
    #1;
  endtask

  task automatic runCycle(in_t x);
    applyStimulus(x);
    checkOutput();
    clockEdge();
  endtask

  vec_t tbl [12];

  initial begin
    in_t nop, x;
    nop = inp(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset release, fill, a load and a store taking the RAM, then a freeze.
    tbl[0]  = mk(inp(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 4'h0, 5'b00000, 0, 0, 0);
    tbl[1]  = mk(nop,                                  1, 0, 0, 4'hF, 5'b00001, 0, 0, 0);
    tbl[2]  = mk(inp(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0), 1, 0, 0, 4'hF, 5'b00011, 0, 0, 0);
    tbl[3]  = mk(inp(0, 1, 0, 0, 0, 0, 6, 1, 1, 0, 0), 1, 0, 0, 4'hF, 5'b00111, 0, 0, 0);
    tbl[4]  = mk(nop,                                  1, 0, 0, 4'hF, 5'b01111, 0, 0, 0);
    tbl[5]  = mk(nop,                                  0, 0, 1, 4'hF, 5'b11110, 0, 1, 0);
    tbl[6]  = mk(nop,                                  1, 0, 0, 4'hF, 5'b11101, 0, 1, 1);
    tbl[7]  = mk(inp(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 1, 0, 0, 4'hF, 5'b11011, 0, 0, 1);
    tbl[8]  = mk(nop,                                  1, 0, 0, 4'hF, 5'b10111, 0, 0, 1);
    tbl[9]  = mk(nop,                                  0, 0, 1, 4'hF, 5'b01110, 1, 0, 1);
    tbl[10] = mk(inp(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 4'h0, 5'b11100, 0, 0, 2);
    tbl[11] = mk(nop,                                  1, 0, 0, 4'hF, 5'b11101, 0, 0, 2);

    applyStimulus(tbl[0].in);
    @(posedge clk); #1;
    $display("[TB] vector table");
    for (int v = 0; v < 12; v++) begin
      applyStimulus(tbl[v].in);
      checkVal("tbl_pc_wren", 32'(pc_wren), 32'(tbl[v].pc));
      checkVal("tbl_pc_redirect", 32'(pc_redirect), 32'(tbl[v].redir));
      checkVal("tbl_ram_addr_src", 32'(ram_addr_src), 32'(tbl[v].ram));
      checkVal("tbl_stage_wren", 32'(stage_wren), 32'(tbl[v].sw));
      checkVal("tbl_stage_valid", 32'(stage_valid), 32'(tbl[v].sv));
      checkVal("tbl_mem_wren", 32'(mem_wren), 32'(tbl[v].mw));
      checkVal("tbl_reg_wren", 32'(reg_wren), 32'(tbl[v].rw));
      checkVal("tbl_stall_cnt", 32'(stall_cnt), 32'(tbl[v].cnt));
      clockEdge();
    end

    $display("[TB] add r3 then sub r4,r3,r5");
    runCycle(inp(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    runCycle(nop);
    runCycle(inp(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0));
    for (int n = 0; n < 6; n++) runCycle(inp(0, 1, 3, 5, 1, 1, 4, 1, 0, 0, 0));
    applyStimulus(nop);
    checkOutput();
    checkVal("raw_stalls_no_bypass", 32'(stall_cnt), 32'd3);
    checkVal("raw_stalls_bypass", 32'(byp_stall_cnt), 32'd2);
    clockEdge();

    $display("[TB] taken branch over a hazard");
    runCycle(inp(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    runCycle(nop);
    runCycle(nop);
    runCycle(inp(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0));
    applyStimulus(inp(0, 1, 3, 0, 1, 0, 0, 0, 0, 1, 1));
    checkOutput();
    checkVal("br_redirect", 32'(pc_redirect), 32'd1);
    checkVal("br_pc_wren", 32'(pc_wren), 32'd1);
    clockEdge();
    applyStimulus(nop);
    checkOutput();
    checkVal("br_flush_valid", 32'(stage_valid), 32'(5'b10001));
    checkVal("br_no_stall", 32'(stall_cnt), 32'd0);
    clockEdge();
    for (int n = 0; n < 4; n++) begin
      applyStimulus(nop);
      checkOutput();
      checkVal("flushed_mem_wren", 32'(mem_wren), 32'd0);
      checkVal("flushed_reg_wren", 32'(reg_wren), 32'd0);
      clockEdge();
    end

    $display("[TB] reset while a store is at the memory stage");
    runCycle(inp(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    runCycle(nop);
    runCycle(inp(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    runCycle(nop);
    x = nop;
    x.reset = 1'b1;
    applyStimulus(x);
    checkOutput();
    checkVal("reset_mem_wren", 32'(mem_wren), 32'd0);
    clockEdge();
    applyStimulus(nop);
    checkOutput();
    checkVal("reset_valids", 32'(stage_valid), 32'(5'b00001));
    clockEdge();

    $display("[TB] back-to-back dependent instructions until saturation");
    runCycle(inp(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int n = 0; n < 30; n++) runCycle(inp(0, 1, 3, 0, 1, 0, 3, 1, 0, 0, 0));
    applyStimulus(nop);
    checkOutput();
    checkVal("stall_saturated", 32'(stall_cnt), 32'(CNT_MAX));
    clockEdge();

    $display("[TB] random stimulus");
    runCycle(inp(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int n = 0; n < 600; n++) begin
      in_t r;
      r.reset = ($urandom_range(0, 59) == 0);
      r.run = ($urandom_range(0, 9) != 0);
      r.rs = 5'($urandom_range(0, 3));
      r.rt = 5'($urandom_range(0, 3));
      r.urs = ($urandom_range(0, 1) == 1);
      r.urt = ($urandom_range(0, 1) == 1);
      r.rd = 5'($urandom_range(0, 3));
      r.rw = ($urandom_range(0, 1) == 1);
      r.mr = ($urandom_range(0, 4) == 0);
      r.mw = ($urandom_range(0, 4) == 0);
      r.bt = ($urandom_range(0, 3) == 0);
      runCycle(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
